arb_req_collector: RTL and testbench



---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_src_slot.sv | 47 ++++
 rtl/arb_req_collector.sv | 134 +++++++++++++
 tb/tb_arb_req_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter package: default sizing and the index-width helper used by
// the arbiter and its request collector.
package arb_pkg;

  localparam int ARB_N_DEF = 8;
  localparam int ARB_W_DEF = 16;

  // Index width for n sources, never narrower than one bit.
  function automatic int id_w(int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage : arb_pkg

// File: rtl/arb_src_slot.sv
// One pending-entry holding register per source: loads when empty and offered,
// clears when the arbiter takes it.
module arb_src_slot
  import arb_pkg::*;
#(
  parameter int W = ARB_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         held_o,
  output logic         ready_o,
  output logic [W-1:0] data_o
);

  logic         held_q, held_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clear_i) begin
      held_d = 1'b0;
    end else if (load_i && !held_q) begin
      held_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

  // No same-cycle refill: a slot only accepts while empty.
  assign ready_o = ~held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule : arb_src_slot

// File: rtl/arb_req_collector.sv
// Round-robin arbiter front end: per-source slots, request gating, grant mux
// and registered output. Grant checker enabled by ARB_REQ_COLLECTOR_CHECK_EN.
module arb_req_collector
  import arb_pkg::*;
#(
  parameter int N    = ARB_N_DEF,
  parameter int W    = ARB_W_DEF,
  parameter int ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    src_valid,
  output logic [N-1:0]    src_ready,
  input  logic [N*W-1:0]  src_data,
  output logic [N-1:0]    request,
  input  logic [N-1:0]    grant,
  input  logic [ID_W-1:0] grant_id,
  input  logic            stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [ID_W-1:0] out_id,
  output logic            err
);

  logic [N-1:0] held;
  logic [N-1:0] slot_clear;
  logic [W-1:0] slot_data [N];

  logic         out_space;
  logic         take;
  logic         take_ok;
  logic         sel_held;
  logic [W-1:0] sel_data;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [ID_W-1:0] out_id_q,    out_id_d;

  for (genvar g = 0; g < N; g++) begin : g_slot
    arb_src_slot #(
      .W(W)
    ) u_slot (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (src_valid[g]),
      .clear_i (slot_clear[g]),
      .data_i  (src_data[g*W +: W]),
      .held_o  (held[g]),
      .ready_o (src_ready[g]),
      .data_o  (slot_data[g])
    );
  end

  assign out_space = ~out_valid_q | out_ready;
  assign request   = held & {N{out_space}};
  assign take      = (grant != '0) & ~stall;

  // grant_id alone selects the source; grant is only the strobe.
  always_comb begin
    sel_held   = 1'b0;
    sel_data   = '0;
    slot_clear = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_held      = held[i];
        sel_data      = slot_data[i];
        slot_clear[i] = take & held[i];
      end
    end
  end

  assign take_ok = take & sel_held;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (take_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_id_d    = grant_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef ARB_REQ_COLLECTOR_CHECK_EN
  logic err_q, err_d;
  logic multi_hot;
  logic id_mismatch;
  logic to_empty;

  assign multi_hot   = (grant & (grant - N'(1))) != '0;
  assign id_mismatch = (grant != '0) && (grant != (N'(1) << grant_id));
  assign to_empty    = |(grant & ~held);

  always_comb begin
    err_d = err_q;
    if (!stall && (multi_hot || id_mismatch || to_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : arb_req_collector

// File: tb/tb_arb_req_collector.sv
// Directed bench for arb_req_collector: vector table plus multi-cycle sequences.
module tb_arb_req_collector;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int ID_W = 3;

`ifdef ARB_REQ_COLLECTOR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*W-1:0]  src_data;
  logic [N-1:0]    request;
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            stall;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [ID_W-1:0] out_id;
  logic            err;

  int checks   = 0;
  int failures = 0;

  arb_req_collector #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .request   (request),
    .grant     (grant),
    .grant_id  (grant_id),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic            rst;
    logic [N-1:0]    sv;
    logic [N*W-1:0]  dat;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gid;
    logic            stl;
    logic            ordy;
    logic [N-1:0]    req;
    logic [N-1:0]    srdy;
    logic            ov;
    logic [W-1:0]    od;
    logic [ID_W-1:0] oid;
    logic            er;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic [7:0] sv, logic [127:0] dat, logic [7:0] gnt,
                              logic [2:0] gid, logic stl, logic ordy, logic [7:0] req,
                              logic [7:0] srdy, logic ov, logic [15:0] od, logic [2:0] oid,
                              logic er);
    vec_t r;
    r.rst = rst; r.sv = sv; r.dat = dat; r.gnt = gnt; r.gid = gid; r.stl = stl; r.ordy = ordy;
    r.req = req; r.srdy = srdy; r.ov = ov; r.od = od; r.oid = oid; r.er = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; src_valid = '0; src_data = '0; grant = '0; grant_id = '0;
    stall = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [127:0] DB, D5;
  logic [15:0]  fl_exp [N];
  int           got;
  int           ptr;
  int           k;
  bit           found;

  initial begin
    reset = 1'b1; src_valid = '0; src_data = '0; grant = '0; grant_id = '0;
    stall = 1'b0; out_ready = 1'b1;

    DB = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA0A0, 16'h0, 16'h1111};
    D5 = 128'h5555;

    //          rst  sv     dat   gnt    gid  stl ordy | req    srdy   ov od        oid er
    tv.push_back(mk(1, 8'h00, '0, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h05, DB, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h04, 3'd2, 0, 1, 8'h05, 8'hFA, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h00, 3'd0, 0, 0, 8'h00, 8'hFE, 1, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h00, 3'd0, 0, 0, 8'h00, 8'hFE, 1, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h00, 3'd0, 0, 1, 8'h01, 8'hFE, 1, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h01, 3'd0, 1, 1, 8'h01, 8'hFE, 0, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h82, 3'd5, 1, 1, 8'h01, 8'hFE, 0, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h01, 3'd0, 0, 1, 8'h01, 8'hFE, 0, 16'hA0A0, 3'd2, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 1, 16'h1111, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h08, 3'd3, 0, 1, 8'h00, 8'hFF, 0, 16'h1111, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, DB, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h1111, 3'd0, CHK));
    tv.push_back(mk(1, 8'h00, '0, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h01, D5, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, D5, 8'h03, 3'd0, 0, 1, 8'h01, 8'hFE, 0, 16'h0000, 3'd0, 0));
    tv.push_back(mk(0, 8'h00, D5, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 1, 16'h5555, 3'd0, CHK));
    tv.push_back(mk(0, 8'h00, D5, 8'h00, 3'd0, 0, 1, 8'h00, 8'hFF, 0, 16'h5555, 3'd0, CHK));

    foreach (tv[i]) begin
      @(negedge clk);
      reset = tv[i].rst; src_valid = tv[i].sv; src_data = tv[i].dat;
      grant = tv[i].gnt; grant_id = tv[i].gid; stall = tv[i].stl; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_request", i),   32'(request),   32'(tv[i].req));
      chk($sformatf("v%0d_src_ready", i), 32'(src_ready), 32'(tv[i].srdy));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tv[i].od));
      chk($sformatf("v%0d_out_id", i),    32'(out_id),    32'(tv[i].oid));
      chk($sformatf("v%0d_err", i),       32'(err),       32'(tv[i].er));
    end

    // Backpressure: output held for 20 cycles, request gated off meanwhile.
    do_reset();
    src_valid = 8'h03;
    src_data  = '0;
    src_data[15:0]  = 16'h0A01;
    src_data[31:16] = 16'h0A02;
    @(negedge clk);
    src_valid = '0; out_ready = 1'b0; grant = 8'h01; grant_id = 3'd0;
    #1;
    chk("bp_request_before", 32'(request), 32'h03);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      grant = '0; grant_id = '0;
      #1;
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'h1);
      chk($sformatf("bp%0d_out_data", c),  32'(out_data),  32'h0A01);
      chk($sformatf("bp%0d_request", c),   32'(request),   32'h00);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_request_release", 32'(request), 32'h02);
    @(negedge clk);
    #1;
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Full load: bench acts as a round-robin arbiter starting at source 3.
    do_reset();
    src_valid = '1;
    for (int i = 0; i < N; i++) begin
      fl_exp[i] = 16'hC0D0 + 16'(i * 16'h0101);
      src_data[i*W +: W] = fl_exp[i];
    end
    got = 0;
    ptr = 3;
    for (int c = 0; c < 40 && got < N; c++) begin
      @(negedge clk);
      src_valid = '0; grant = '0; grant_id = '0;
      #1;
      if (out_valid) begin
        chk($sformatf("fl%0d_out_id", got), 32'(out_id), 32'((3 + got) % N));
        chk($sformatf("fl%0d_out_data", got), 32'(out_data), 32'(fl_exp[(3 + got) % N]));
        got++;
      end
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        k = (ptr + j) % N;
        if (!found && request[k]) begin
          found = 1'b1;
          grant = N'(1) << k;
          grant_id = ID_W'(k);
          ptr = (k + 1) % N;
        end
      end
    end
    chk("fl_output_count", 32'(got), 32'(N));

    // Reset mid-operation: output full and three slots held, all discarded.
    do_reset();
    src_valid = 8'h0F;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 16'hE000 + 16'(i);
    @(negedge clk);
    src_valid = '0; out_ready = 1'b0; grant = 8'h02; grant_id = 3'd1;
    @(negedge clk);
    grant = '0; grant_id = '0;
    #1;
    chk("rm_pre_out_valid", 32'(out_valid), 32'h1);
    chk("rm_pre_src_ready", 32'(src_ready), 32'hF2);
    out_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rm_out_valid", 32'(out_valid), 32'h0);
    chk("rm_request",   32'(request),   32'h00);
    chk("rm_src_ready", 32'(src_ready), 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rm%0d_request", c),   32'(request),   32'h00);
      chk($sformatf("rm%0d_out_valid", c), 32'(out_valid), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_arb_req_collector
